// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter in front of a single 8N1 UART transmitter.
// One frame per grant; every output is a flop.
module uart_tx_sched #(
  parameter int NREQ     = 4,
  parameter int BAUD_DIV = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [8*NREQ-1:0]       data_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    tx_o,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] src_o
);
  localparam int SW = $clog2(NREQ);
  localparam int BW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic [SW-1:0]   src_q, src_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [SW-1:0]   win, idx;
  logic            found;
  logic            bit_end;

  // Search starts just after the last granted requester and wraps.
  always_comb begin
    win   = src_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = SW'((int'(src_q) + i) % NREQ);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign bit_end = (baud_q == BW'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    src_d   = src_q;
    gnt_d   = '0;
    tx_d    = tx_q;
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (found) begin
          state_d    = START;
          data_d     = data_i[{win, 3'b000} +: 8];
          gnt_d[win] = 1'b1;
          src_d      = win;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = data_q[bit_d];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      src_q   <= SW'(NREQ - 1);
      gnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      src_q   <= src_d;
      gnt_q   <= gnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign src_o  = src_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench; a frame-level model predicts grants
// and the expected line waveform, a monitor compares every cycle.
module tb_uart_tx_sched;
  localparam int N  = 4;
  localparam int BD = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_i = '0;
  logic [8*N-1:0] data_i = '0;
  logic [N-1:0]   gnt_o;
  logic           tx_o;
  logic           busy_o;
  logic [1:0]     src_o;

  uart_tx_sched #(.NREQ(N), .BAUD_DIV(BD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req_i),
    .data_i (data_i),
    .gnt_o  (gnt_o),
    .tx_o   (tx_o),
    .busy_o (busy_o),
    .src_o  (src_o)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     w;
    longint c;
  } exp_t;

  exp_t       sq[$];
  exp_t       me;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [N-1:0] pend = '0;
  logic [7:0] pdata [N];
  int         last = N - 1;
  longint     free_c = 0;
  longint     fg = -100000;
  logic [7:0] fbyte = '0;
  int         ngr = 0;
  bit         jg = 0;
  int         jw = 0;
  bit         rearm = 0;
  bit         chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Line level for the current cycle: start, 8 data bits LSB first, stop.
  function automatic logic exp_tx();
    int k;
    logic [7:0] t;
    if (cyc < fg || cyc >= fg + 10 * BD) return 1'b1;
    k = int'((cyc - fg) / BD);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    t = fbyte >> (k - 1);
    return t[0];
  endfunction

  function automatic logic exp_busy();
    return (cyc >= fg && cyc < fg + 10 * BD);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (gnt_o != '0) begin
        if (sq.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt_o), 32'd0);
        end else begin
          me = sq.pop_front();
          chk("gnt_onehot", 32'(gnt_o), 32'd1 << me.w);
          chk("src", 32'(src_o), 32'(me.w));
          chk("gnt_cycle", 32'(cyc), 32'(me.c));
        end
      end else if (sq.size() != 0 && sq[0].c < cyc) begin
        chk("missing_gnt", 32'(gnt_o), 32'd1 << sq[0].w);
        void'(sq.pop_front());
      end
      chk("tx", 32'(tx_o), 32'(exp_tx()));
      chk("busy", 32'(busy_o), 32'(exp_busy()));
    end
  end

  task automatic raise(int k, logic [7:0] b);
    pend[k] = 1'b1;
    pdata[k] = b;
    req_i[k] = 1'b1;
    data_i[8*k +: 8] = b;
  endtask

  task automatic drop(int k);
    pend[k] = 1'b0;
    req_i[k] = 1'b0;
    data_i[8*k +: 8] = 8'($urandom);
  endtask

  function automatic int rr();
    for (int i = 1; i <= N; i++)
      if (pend[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // Decide this edge's grant from the model, then advance one cycle.
  task automatic tick();
    if (cyc + 1 >= free_c && pend != '0) begin
      jw = rr();
      sq.push_back('{jw, cyc + 1});
      last = jw;
      fg = cyc + 1;
      fbyte = pdata[jw];
      free_c = cyc + 1 + 10 * BD + 1;
      jg = 1;
      ngr++;
    end
    @(negedge clk);
    if (jg) begin
      jg = 0;
      drop(jw);
      if (rearm) raise(jw, 8'($urandom));
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic wait_quiet();
    int b;
    b = 0;
    while ((pend != '0 || cyc + 1 < free_c) && b < 3000) begin
      tick();
      b++;
    end
    if (b >= 3000) chk("quiet_timeout", 32'(b), 32'd0);
  endtask

  initial begin
    int b;
    int tgt;
    int k;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_src", 32'(src_o), 32'(N - 1));
    rst = 1'b0;
    chk_en = 1;

    raise(0, 8'h55);
    wait_quiet();
    run(3);
    raise(1, 8'hA3);
    wait_quiet();
    run(3);

    rearm = 1;
    for (int i = 0; i < N; i++) raise(i, 8'($urandom));
    tgt = ngr + 6;
    b = 0;
    while (ngr < tgt && b < 3000) begin
      tick();
      b++;
    end
    if (b >= 3000) chk("fair_timeout", 32'(ngr), 32'(tgt));
    rearm = 0;
    for (int i = 0; i < N; i++) drop(i);
    wait_quiet();

    raise(2, 8'($urandom));
    run(3);
    raise(0, 8'($urandom));
    raise(2, 8'($urandom));
    wait_quiet();

    raise(3, 8'($urandom));
    run(20);
    raise(1, 8'($urandom));
    run(30);
    drop(1);
    wait_quiet();
    run(20);

    repeat (4000) begin
      if ($urandom_range(0, 19) == 0) begin
        k = int'($urandom_range(0, N - 1));
        if (!pend[k]) raise(k, 8'($urandom));
      end
      if ($urandom_range(0, 59) == 0) begin
        k = int'($urandom_range(0, N - 1));
        if (pend[k]) drop(k);
      end
      tick();
    end
    wait_quiet();
    run(5);

    raise(0, 8'h00);
    tick();
    b = 0;
    while (cyc < fg + 40 && b < 100) begin
      tick();
      b++;
    end
    chk_en = 0;
    #2 rst = 1'b1;
    #1;
    chk("abort_tx", 32'(tx_o), 32'd1);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_gnt", 32'(gnt_o), 32'd0);
    chk("abort_src", 32'(src_o), 32'(N - 1));
    sq.delete();
    for (int i = 0; i < N; i++) drop(i);
    last = N - 1;
    fg = -100000;
    free_c = 0;
    jg = 0;
    repeat (3) @(negedge clk);
    chk("hold_tx", 32'(tx_o), 32'd1);
    chk("hold_busy", 32'(busy_o), 32'd0);
    raise(3, 8'($urandom));
    rst = 1'b0;
    chk_en = 1;
    wait_quiet();
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_cmp, n_fail);
    $finish;
  end
endmodule
